line_window_reader: RTL and testbench
=====================================

// Module: line_window_reader
// PURPOSE
//   Consumer end of the pixel line-delay path for edge detection.
//   Takes the raster pixel stream from the camera capture block.
//   Keeps two line stores with read-before-write access and assembles a 3x3 pixel window.
//   Presents the window to the Sobel stage with valid and coordinates.
// PARAMETERS
//   PIX_W       12   pixel width (RGB444)
//   LINE_WIDTH  640  pixels per line; also the depth of each line store
//   FRAME_LINES 480  lines per frame; row counter wraps after this
//   COL_W       10   column counter width (>= clog2(LINE_WIDTH))
//   ROW_W       9    row counter width (>= clog2(FRAME_LINES))
// PORTS
//   clk          in   1         pixel clock; all logic on rising edge
//   reset        in   1         asynchronous, active-high
//   pix_in       in   PIX_W     incoming pixel
//   pix_valid    in   1         pix_in valid this cycle; no backpressure
//   frame_start  in   1         1-cycle pulse marking the first pixel of a frame
//   win_out      out  9*PIX_W   window; tap k=3*r+c at [PIX_W*k +: PIX_W]
//                               r=0 is oldest line, c=0 is oldest column; k=4 is the centre
//   win_valid    out  1         win_out/win_row/win_col valid (1-cycle pulse per window)
//   win_row      out  ROW_W     row of newest pixel in window (tap 8)
//   win_col      out  COL_W     column of newest pixel in window (tap 8)
// BEHAVIOUR
//   - Reset (async): col, row, 3x3 window regs, win_out, win_valid, win_row, win_col all 0.
//     Line store contents are not cleared; row gating masks them.
//   - Counters:
//     - col increments on each pix_valid; LINE_WIDTH-1 wraps to 0 and row increments.
//     - row wraps FRAME_LINES-1 -> 0.
//   - frame_start:
//     - With pix_valid high: that pixel is (row 0, col 0), and counters continue from there.
//     - Without pix_valid: counters clear to 0, and the next pix_valid is (0,0).
//   - Line stores (lb1 = row-1, lb2 = row-2), on pix_valid at column col:
//     - Read lb1[col] -> a1 and lb2[col] -> a2.
//     - Write lb1[col] <= pix_in and lb2[col] <= a1.
//     - Same-cycle read returns OLD data (read-before-write).
//   - Window shift on pix_valid: columns c0 <= c1, c1 <= c2, c2 <= {a2, a1, pix_in} (r0, r1, r2).
//   - Latency: win_* updates on the clock edge that samples the pix_valid pixel.
//     - Visible exactly 1 cycle after the input cycle.
//     - No pix_valid means win_valid=0 next cycle; win_out, win_row and win_col hold their values.
//   - Line wrap: the window is not flushed at end of line. Taps from the previous line's tail are gated by the column rule below.
//   - win_row/win_col carry the row/col of the pixel just written (before the increment).
// CONFIGURATION
//   BORDER_ZERO_EN undefined (default):
//     - win_valid=1 only when the written pixel has row>=2 && col>=2 (full in-frame window).
//     - Yields (FRAME_LINES-2)*(LINE_WIDTH-2) windows per frame.
//   BORDER_ZERO_EN defined:
//     - win_valid=1 for every pix_valid.
//     - Taps outside the frame are forced to 0 in win_out:
//       - row==0 zeros r0,r1; row==1 zeros r0.
//       - col==0 zeros c0,c1; col==1 zeros c0.
//     - Yields FRAME_LINES*LINE_WIDTH windows per frame.
// TESTING (LINE_WIDTH=8, FRAME_LINES=6 unless noted; pixel value = row*16+col)
//   1. Reset mid-frame (assert at row 3 col 5):
//      - win_valid=0 and all outputs 0 within the same cycle.
//      - After release plus frame_start, windows restart at row 0.
//   2. Full frame, macro off:
//      - Exactly 24 win_valid pulses.
//      - First pulse: win_row=2, win_col=2, taps = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22} for k=0..8.
//   3. Line wrap, macro off:
//      - Pixels at row 3 col 0 and col 1 give win_valid=0.
//      - col 2 gives win_valid=1 with tap8=0x32 and tap0=0x10.
//   4. Gapped pix_valid (1 valid per 3 cycles):
//      - Same window sequence and count as test 2.
//      - win_out holds between pulses.
//   5. frame_start with pix_valid at row 4 col 3 (early restart):
//      - Counters restart at (0,0).
//      - No win_valid until row 2 col 2 of the new frame (macro off).
//   6. BORDER_ZERO_EN:
//      - Pixel (0,0) gives win_valid=1 with only tap8=0x00 source and all other taps 0.
//      - Pixel (1,1) has taps 0..3 and 6 equal to 0, tap4=0x00, tap5=0x01, tap7=0x10, tap8=0x11.
//      - 48 pulses per frame.

Source files
------------

// File: rtl/line_window_reader.sv
// line_window_reader
//   Consumer end of the pixel line-delay path. Two line stores (lb1 = previous
//   line, lb2 = the line before that) feed a 3x3 shift window. The window is
//   presented to the Sobel stage with a valid pulse and the row/column of the
//   newest pixel (tap 8).
//   Tap k = 3*r + c sits at win_out[PIX_W*k +: PIX_W]. r=0 is the oldest line
//   and c=0 is the oldest column.
//   Optional build macro BORDER_ZERO_EN:
//     - undefined: only full in-frame windows (row>=2, col>=2) are flagged valid.
//     - defined:   every pixel produces a window, and out-of-frame taps are zeroed.
module line_window_reader #(
  parameter int PIX_W       = 12,
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               frame_start,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  output logic [ROW_W-1:0]   win_row,
  output logic [COL_W-1:0]   win_col
);

  // Raster position counters.
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;

  // Line stores. Reads are combinational, so they return the contents from
  // before this edge's write (read-before-write).
  logic [PIX_W-1:0] lb1_mem [LINE_WIDTH];
  logic [PIX_W-1:0] lb2_mem [LINE_WIDTH];
  logic [PIX_W-1:0] a1, a2;

  // 3x3 window, indexed [row][col].
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

  // Registered outputs.
  logic [9*PIX_W-1:0] win_out_q, win_out_d;
  logic               win_valid_q, win_valid_d;
  logic [ROW_W-1:0]   win_row_q, win_row_d;
  logic [COL_W-1:0]   win_col_q, win_col_d;

  // Position of the pixel being accepted. A frame_start pulse forces it to (0,0).
  always_comb begin
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
    a1      = lb1_mem[cur_col];
    a2      = lb2_mem[cur_col];
  end

  // Next-state for the counters, the window and the output registers.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // a combinational output unassigned infers a latch.
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_out_d   = win_out_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    if (pix_valid) begin
      // Advance the raster position. The column wraps into a row increment.
      if (cur_col == COL_W'(LINE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(FRAME_LINES - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end

      // Shift the window one column and load the newest column from the
      // line stores and the incoming pixel.
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = a2;
      win_d[1][2] = a1;
      win_d[2][2] = pix_in;

      // Flatten into the output bus.
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
`ifdef BORDER_ZERO_EN
          if ((cur_row == ROW_W'(0) && r < 2) || (cur_row == ROW_W'(1) && r == 0) ||
              (cur_col == COL_W'(0) && c < 2) || (cur_col == COL_W'(1) && c == 0))
            win_out_d[PIX_W*(3*r+c) +: PIX_W] = '0;
          else
            win_out_d[PIX_W*(3*r+c) +: PIX_W] = win_d[r][c];
`else
          win_out_d[PIX_W*(3*r+c) +: PIX_W] = win_d[r][c];
`endif
        end
      end

`ifdef BORDER_ZERO_EN
      win_valid_d = 1'b1;
`else
      win_valid_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
`endif
      win_row_d = cur_row;
      win_col_d = cur_col;
    end else if (frame_start) begin
      // A frame_start without a pixel clears the position, so the next pixel is (0,0).
      col_d = '0;
      row_d = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_out_q   <= win_out_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Line store writes. The previous line moves down into lb2 as the new pixel enters lb1.
  always_ff @(posedge clk) begin
    // NOTE: the stores have no reset. Stale contents only reach windows that
    // the row gating rejects or zeroes, and leaving them unreset keeps them
    // mappable to RAM.
    if (pix_valid) begin
      lb1_mem[cur_col] <= pix_in;
      lb2_mem[cur_col] <= a1;
    end
  end

  assign win_out   = win_out_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_line_window_reader.sv
// Directed bench for line_window_reader with an 8x6 frame. Pixel value = row*16+col.
// Expected windows come from a coordinate model: tap (r,c) of the window whose
// newest pixel is (R,C) holds pixel (R-2+r, C-2+c), or 0 outside the frame.
module tb_line_window_reader;

  localparam int PIX_W = 12;
  localparam int LW    = 8;
  localparam int FL    = 6;
  localparam int COL_W = 3;
  localparam int ROW_W = 3;
`ifdef BORDER_ZERO_EN
  localparam int EXP_PULSES = FL * LW;
`else
  localparam int EXP_PULSES = (FL - 2) * (LW - 2);
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               frame_start;
  logic [9*PIX_W-1:0] win_out;
  logic               win_valid;
  logic [ROW_W-1:0]   win_row;
  logic [COL_W-1:0]   win_col;

  int total = 0;
  int bad   = 0;

  line_window_reader #(
    .PIX_W(PIX_W), .LINE_WIDTH(LW), .FRAME_LINES(FL), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .frame_start(frame_start), .win_out(win_out), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] pv(input int r, input int c);
    return PIX_W'(r * 16 + c);
  endfunction

  function automatic logic [9*PIX_W-1:0] exp_win(input int r, input int c);
    logic [9*PIX_W-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        if (r - 2 + rr >= 0 && c - 2 + cc >= 0)
          w[PIX_W*(3*rr+cc) +: PIX_W] = pv(r - 2 + rr, c - 2 + cc);
      end
    end
    return w;
  endfunction

  function automatic logic exp_valid(input int r, input int c);
`ifdef BORDER_ZERO_EN
    return (r >= 0) && (c >= 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic fs, input logic [PIX_W-1:0] p);
    pix_valid   = v;
    frame_start = fs;
    pix_in      = p;
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    pix_in      = '0;
  endtask

  // One full frame starting with frame_start, with `gap` idle cycles after each pixel.
  task automatic run_frame(input int gap, input string tag);
    int pulses;
    pulses = 0;
    for (int r = 0; r < FL; r++) begin
      for (int c = 0; c < LW; c++) begin
        logic ev;
        logic [9*PIX_W-1:0] w;
        step(1'b1, (r == 0 && c == 0), pv(r, c));
        ev = exp_valid(r, c);
        w  = exp_win(r, c);
        if (win_valid === 1'b1) pulses++;
        total++;
        if (win_valid !== ev) begin
          bad++;
          $display("FAIL %s_valid r%0d c%0d: got %b want %b", tag, r, c, win_valid, ev);
        end
        if (ev) begin
          total++;
          if (win_out !== w || win_row !== ROW_W'(r) || win_col !== COL_W'(c)) begin
            bad++;
            $display("FAIL %s_window r%0d c%0d: got row=%0d col=%0d win=%h want win=%h",
                     tag, r, c, win_row, win_col, win_out, w);
          end
        end
        for (int g = 0; g < gap; g++) begin
          step(1'b0, 1'b0, '0);
          if (win_valid === 1'b1) pulses++;
          total++;
          if (win_valid !== 1'b0 ||
              (ev && (win_out !== w || win_row !== ROW_W'(r) || win_col !== COL_W'(c)))) begin
            bad++;
            $display("FAIL %s_hold r%0d c%0d g%0d: got valid=%b win=%h want valid=0 win=%h",
                     tag, r, c, g, win_valid, win_out, w);
          end
        end
      end
    end
    total++;
    if (pulses != EXP_PULSES) begin
      bad++;
      $display("FAIL %s_count: got %0d want %0d", tag, pulses, EXP_PULSES);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; pix_in = '0;
    #12;
    total++;
    if (win_valid !== 1'b0 || win_out !== '0 || win_row !== '0 || win_col !== '0) begin
      bad++;
      $display("FAIL reset_init: got valid=%b row=%0d col=%0d win=%h want all 0",
               win_valid, win_row, win_col, win_out);
    end
    @(negedge clk);
    reset = 1'b0;
    // Run into the middle of a frame, up to row 3 col 5.
    for (int i = 0; i <= 3 * LW + 5; i++) step(1'b1, (i == 0), pv(i / LW, i % LW));
    total++;
    if (win_valid !== 1'b1 || win_row !== ROW_W'(3) || win_col !== COL_W'(5)) begin
      bad++;
      $display("FAIL reset_pre: got valid=%b row=%0d col=%0d want 1 3 5", win_valid, win_row, win_col);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (win_valid !== 1'b0 || win_out !== '0 || win_row !== '0 || win_col !== '0) begin
      bad++;
      $display("FAIL reset_async: got valid=%b row=%0d col=%0d win=%h want all 0",
               win_valid, win_row, win_col, win_out);
    end
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, "post_reset");
  endtask

  task automatic test_full_frame();
    run_frame(0, "full");
  endtask

  task automatic test_gapped();
    run_frame(2, "gapped");
  endtask

  task automatic test_line_wrap();
    for (int i = 0; i < 3 * LW; i++) step(1'b1, (i == 0), pv(i / LW, i % LW));
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, pv(3, c));
      total++;
      if (win_valid !== exp_valid(3, c) || win_row !== ROW_W'(3) || win_col !== COL_W'(c)) begin
        bad++;
        $display("FAIL wrap_col%0d: got valid=%b row=%0d col=%0d want valid=%b",
                 c, win_valid, win_row, win_col, exp_valid(3, c));
      end
    end
    step(1'b1, 1'b0, pv(3, 2));
    total++;
    if (win_valid !== 1'b1 || win_out[PIX_W*8 +: PIX_W] !== 12'h032 ||
        win_out[0 +: PIX_W] !== 12'h010) begin
      bad++;
      $display("FAIL wrap_col2: got valid=%b tap8=%h tap0=%h want 1 032 010",
               win_valid, win_out[PIX_W*8 +: PIX_W], win_out[0 +: PIX_W]);
    end
  endtask

  // Continues from row 3 col 2 left by test_line_wrap.
  task automatic test_early_restart();
    for (int i = 3 * LW + 3; i < 4 * LW + 3; i++) step(1'b1, 1'b0, pv(i / LW, i % LW));
    step(1'b1, 1'b1, pv(0, 0));
    total++;
    if (win_row !== '0 || win_col !== '0 || win_valid !== exp_valid(0, 0)) begin
      bad++;
      $display("FAIL restart_origin: got valid=%b row=%0d col=%0d want row=0 col=0 valid=%b",
               win_valid, win_row, win_col, exp_valid(0, 0));
    end
    for (int i = 1; i <= 2 * LW + 2; i++) begin
      step(1'b1, 1'b0, pv(i / LW, i % LW));
      total++;
      if (win_valid !== exp_valid(i / LW, i % LW) ||
          win_row !== ROW_W'(i / LW) || win_col !== COL_W'(i % LW)) begin
        bad++;
        $display("FAIL restart_pos i%0d: got valid=%b row=%0d col=%0d want valid=%b row=%0d col=%0d",
                 i, win_valid, win_row, win_col, exp_valid(i / LW, i % LW), i / LW, i % LW);
      end
    end
    total++;
    if (win_out !== exp_win(2, 2)) begin
      bad++;
      $display("FAIL restart_first: got %h want %h", win_out, exp_win(2, 2));
    end
  endtask

`ifdef BORDER_ZERO_EN
  task automatic test_border();
    logic [9*PIX_W-1:0] e;
    step(1'b1, 1'b1, pv(0, 0));
    total++;
    if (win_valid !== 1'b1 || win_out !== '0) begin
      bad++;
      $display("FAIL border_00: got valid=%b win=%h want 1 0", win_valid, win_out);
    end
    for (int i = 1; i <= LW + 1; i++) step(1'b1, 1'b0, pv(i / LW, i % LW));
    e = '0;
    e[PIX_W*5 +: PIX_W] = 12'h001;
    e[PIX_W*7 +: PIX_W] = 12'h010;
    e[PIX_W*8 +: PIX_W] = 12'h011;
    total++;
    if (win_valid !== 1'b1 || win_out !== e) begin
      bad++;
      $display("FAIL border_11: got valid=%b win=%h want 1 %h", win_valid, win_out, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_line_wrap();
    test_early_restart();
`ifdef BORDER_ZERO_EN
    test_border();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
